// File: rtl/jamma_joy_scanner_pkg.sv
// Shared types and constants for the JAMMA joystick scanner.
package jamma_pkg;

   localparam int JOY_W  = 8;
   localparam int COIN_W = 2;

   // Active-low inputs: all ones means nothing pressed.
   localparam logic [JOY_W-1:0]  JOY_IDLE  = 8'hFF;
   localparam logic [COIN_W-1:0] COIN_IDLE = 2'b11;

   typedef enum logic [1:0] {
      SETTLE_A = 2'd0,
      SAMPLE_A = 2'd1,
      SETTLE_B = 2'd2,
      SAMPLE_B = 2'd3
   } scan_state_t;

endpackage

// File: rtl/jamma_joy_scanner_if.sv
// Board-pin and core-side signals of the joystick scanner.
// Handshake: there is none. No valid/ready pair and no back-pressure; joy1,
// joy2 and coin are registered and may be read on any cycle, and scan_done
// is a single-cycle strobe marking the end of each complete A+B scan.
interface jamma_joy_scanner_if;
   import jamma_pkg::*;

   logic [JOY_W-1:0]  JJOY;
   logic [COIN_W-1:0] JCOIN;
   logic [5:0]        local_joy;
   logic              JSELECT;
   logic [JOY_W-1:0]  joy1;
   logic [JOY_W-1:0]  joy2;
   logic [COIN_W-1:0] coin;
   logic              scan_done;
   scan_state_t       dbg_state;

   modport slave (
      input  JJOY, JCOIN, local_joy,
      output JSELECT, joy1, joy2, coin, scan_done, dbg_state
   );

   modport master (
      output JJOY, JCOIN, local_joy,
      input  JSELECT, joy1, joy2, coin, scan_done, dbg_state
   );

endinterface

// File: rtl/jamma_joy_scanner_debounce.sv
// Per-bit sample-count debouncer; only advances on a sample strobe.
module joy_debounce #(
   parameter int WIDTH            = 8,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             strobe,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SAMPLES - 1);

   logic [3:0]       r_cnt [WIDTH];
   logic [WIDTH-1:0] r_dout;

   // Count consecutive differing samples per bit; commit on the last one.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= '1;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= 4'd0;
      end else if (strobe) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (din[i] == r_dout[i]) begin
               r_cnt[i] <= 4'd0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_dout[i] <= din[i];
               r_cnt[i]  <= 4'd0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign dout = r_dout;

endmodule

// File: rtl/jamma_joy_scanner.sv
// Scans the shared JJOY splitter bus for two players and debounces the result.
module jamma_joy_scanner
   import jamma_pkg::*;
#(
   parameter int SETTLE_CYCLES    = 16,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input logic                pclk,
   input logic                rst_n,
   jamma_joy_scanner_if.slave bus
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   logic [5:0]        r_local_s1, r_local_s2;
   logic [COIN_W-1:0] r_coin_s1, r_coin_s2;
   scan_state_t       r_state, w_state_nxt;
   logic [7:0]        r_settle_cnt, w_settle_nxt;
   logic              r_jselect, w_jselect_nxt;
   logic              r_scan_done;
   logic              w_strobe_a, w_strobe_b;
   logic [JOY_W-1:0]  w_raw_a;
   logic [JOY_W-1:0]  w_joy1, w_joy2;
   logic [COIN_W-1:0] w_coin;

   // Two-flop synchronizers for the inputs that are asynchronous to pclk.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_local_s1 <= '1;
         r_local_s2 <= '1;
         r_coin_s1  <= COIN_IDLE;
         r_coin_s2  <= COIN_IDLE;
      end else begin
         r_local_s1 <= bus.local_joy;
         r_local_s2 <= r_local_s1;
         r_coin_s1  <= bus.JCOIN;
         r_coin_s2  <= r_coin_s1;
      end
   end

   // Scan state, settle counter, select line and end-of-scan strobe.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= SETTLE_A;
         r_settle_cnt <= 8'd0;
         r_jselect    <= 1'b0;
         r_scan_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_jselect    <= w_jselect_nxt;
         r_scan_done  <= (r_state == SAMPLE_B);
      end
   end

   // Next-state logic: settle for SETTLE_CYCLES, then one sample cycle per player.
   always_comb begin
      w_state_nxt   = r_state;
      w_settle_nxt  = r_settle_cnt;
      w_jselect_nxt = r_jselect;
      w_strobe_a    = 1'b0;
      w_strobe_b    = 1'b0;
      case (r_state)
         SETTLE_A: begin
            if (r_settle_cnt == SETTLE_LAST) begin
               w_state_nxt  = SAMPLE_A;
               w_settle_nxt = 8'd0;
            end else begin
               w_settle_nxt = r_settle_cnt + 8'd1;
            end
         end
         SAMPLE_A: begin
            w_strobe_a    = 1'b1;
            w_state_nxt   = SETTLE_B;
            w_jselect_nxt = 1'b1;
         end
         SETTLE_B: begin
            if (r_settle_cnt == SETTLE_LAST) begin
               w_state_nxt  = SAMPLE_B;
               w_settle_nxt = 8'd0;
            end else begin
               w_settle_nxt = r_settle_cnt + 8'd1;
            end
         end
         SAMPLE_B: begin
            w_strobe_b    = 1'b1;
            w_state_nxt   = SETTLE_A;
            w_jselect_nxt = 1'b0;
         end
         default: begin
            w_state_nxt   = SETTLE_A;
            w_settle_nxt  = 8'd0;
            w_jselect_nxt = 1'b0;
         end
      endcase
   end

   // Local joystick shares player 1; start and bit 6 come only from the bus.
   assign w_raw_a = bus.JJOY & {2'b11, r_local_s2};

   joy_debounce #(.WIDTH(JOY_W), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_a (
      .pclk(pclk), .rst_n(rst_n), .strobe(w_strobe_a), .din(w_raw_a), .dout(w_joy1)
   );

   joy_debounce #(.WIDTH(JOY_W), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_b (
      .pclk(pclk), .rst_n(rst_n), .strobe(w_strobe_b), .din(bus.JJOY), .dout(w_joy2)
   );

   joy_debounce #(.WIDTH(COIN_W), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb_coin (
      .pclk(pclk), .rst_n(rst_n), .strobe(w_strobe_b), .din(r_coin_s2), .dout(w_coin)
   );

   assign bus.JSELECT   = r_jselect;
   assign bus.joy1      = w_joy1;
   assign bus.joy2      = w_joy2;
   assign bus.coin      = w_coin;
   assign bus.scan_done = r_scan_done;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Self-checking bench for jamma_joy_scanner (SETTLE_CYCLES=4, DEBOUNCE_SAMPLES=3).
module tb_jamma_joy_scanner;
   import jamma_pkg::*;

   localparam int PERIOD = 10;

   typedef struct {
      logic [7:0] p1;
      logic [7:0] p2;
      logic [5:0] loc;
      logic [1:0] jc;
      int         hold;
      logic [7:0] e1;
      logic [7:0] e2;
      logic [1:0] ec;
   } vec_t;

   logic pclk;
   logic rst_n;
   logic [7:0] tb_p1;
   logic [7:0] tb_p2;
   int n_vec;
   int n_fail;
   logic [17:0] exp_q[$];
   vec_t vecs[16];

   jamma_joy_scanner_if bus();

   jamma_joy_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SAMPLES(3)) dut (
      .pclk(pclk), .rst_n(rst_n), .bus(bus)
   );

   // Splitter model: the bus shows whichever player JSELECT picks.
   assign bus.JJOY = bus.JSELECT ? tb_p2 : tb_p1;

   // Clock and reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance until n scan_done pulses have been seen, bounded by a cycle budget.
   task automatic wait_scans(input int n);
      int seen;
      int cyc;
      seen = 0;
      cyc  = 0;
      while (seen < n && cyc < (n + 1) * PERIOD) begin
         tick();
         cyc++;
         if (bus.scan_done) seen++;
      end
      if (seen < n) begin
         n_vec++;
         n_fail++;
         $display("FAIL scan_timeout: got %0d scans expected %0d", seen, n);
      end
   endtask

   task automatic drive(input logic [7:0] p1, input logic [7:0] p2,
                        input logic [5:0] loc, input logic [1:0] jc);
      tb_p1         = p1;
      tb_p2         = p2;
      bus.local_joy = loc;
      bus.JCOIN     = jc;
   endtask

   function automatic vec_t mk(input logic [7:0] p1, input logic [7:0] p2, input logic [5:0] loc,
                               input logic [1:0] jc, input int hold, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [1:0] ec);
      vec_t v;
      v.p1 = p1; v.p2 = p2; v.loc = loc; v.jc = jc; v.hold = hold;
      v.e1 = e1; v.e2 = e2; v.ec = ec;
      return v;
   endfunction

   initial begin
      logic [17:0] exp;
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      drive(8'hFF, 8'hFF, 6'h3F, 2'b11);

      // Deterministic vectors; debounce history carries from one to the next.
      vecs[0] = mk(8'hFE, 8'h7F, 6'h3F, 2'b11, 3, 8'hFE, 8'h7F, 2'b11); // separation
      vecs[1] = mk(8'hFF, 8'hFF, 6'h3B, 2'b11, 3, 8'hFB, 8'hFF, 2'b11); // local merge
      vecs[2] = mk(8'hFF, 8'hFF, 6'h3F, 2'b10, 3, 8'hFF, 8'hFF, 2'b10); // coin in
      vecs[3] = mk(8'hFF, 8'hFF, 6'h3F, 2'b11, 2, 8'hFF, 8'hFF, 2'b10); // release, not yet
      vecs[4] = mk(8'hFF, 8'hFF, 6'h3F, 2'b11, 1, 8'hFF, 8'hFF, 2'b11); // third scan
      vecs[5] = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 2, 8'hFF, 8'hFF, 2'b11); // glitch 2 samples
      vecs[6] = mk(8'hFF, 8'hFF, 6'h3F, 2'b11, 1, 8'hFF, 8'hFF, 2'b11); // match clears
      vecs[7] = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 2, 8'hFF, 8'hFF, 2'b11); // count restarted
      vecs[8] = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 1, 8'hFE, 8'hFF, 2'b11); // third sample
      vecs[9] = mk(8'hFF, 8'h00, 6'h3F, 2'b01, 3, 8'hFF, 8'h00, 2'b01);
      for (int i = 10; i < 16; i++) begin
         logic [7:0] rp1, rp2;
         logic [5:0] rl;
         logic [1:0] rc;
         rp1 = 8'($urandom_range(0, 255));
         rp2 = 8'($urandom_range(0, 255));
         rl  = 6'($urandom_range(0, 63));
         rc  = 2'($urandom_range(0, 3));
         vecs[i] = mk(rp1, rp2, rl, rc, 3, rp1 & {2'b11, rl}, rp2, rc);
      end

      // Reset state
      repeat (3) tick();
      check("rst_jselect", 32'(bus.JSELECT), 32'd0);
      check("rst_joy1", 32'(bus.joy1), 32'hFF);
      check("rst_joy2", 32'(bus.joy2), 32'hFF);
      check("rst_coin", 32'(bus.coin), 32'h3);
      check("rst_scan_done", 32'(bus.scan_done), 32'd0);
      rst_n = 1'b1;

      // Idle scanning: JSELECT 0x5 / 1x5, scan_done every 10 cycles, outputs idle.
      for (int n = 0; n <= 30; n++) begin
         check("idle_jselect", 32'(bus.JSELECT), 32'((n % PERIOD) >= 5));
         check("idle_scan_done", 32'(bus.scan_done), 32'(n > 0 && (n % PERIOD) == 0));
         check("idle_joy", {8'h0, bus.joy1, bus.joy2, 6'h0, bus.coin}, {8'h0, 8'hFF, 8'hFF, 8'h3});
         if (n < 30) tick();
      end

      // Table: push expected on drive, pop when the final scan of the vector completes.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].p1, vecs[i].p2, vecs[i].loc, vecs[i].jc);
         exp_q.push_back({vecs[i].e1, vecs[i].e2, vecs[i].ec});
         wait_scans(vecs[i].hold);
         exp = exp_q.pop_front();
         check($sformatf("vec%0d_joy1", i), 32'(bus.joy1), 32'(exp[17:10]));
         check($sformatf("vec%0d_joy2", i), 32'(bus.joy2), 32'(exp[9:2]));
         check($sformatf("vec%0d_coin", i), 32'(bus.coin), 32'(exp[1:0]));
      end

      // Exact commit edge: third differing sample lands on the edge ending SAMPLE_A.
      drive(8'hFF, 8'hFF, 6'h3F, 2'b11);
      wait_scans(3);
      check("edge_pre_joy1", 32'(bus.joy1), 32'hFF);
      tb_p1 = 8'hFD;
      wait_scans(2);
      for (int n = 1; n <= 5; n++) begin
         tick();
         if (n == 4) check("edge_before_joy1", 32'(bus.joy1), 32'hFF);
         if (n == 5) check("edge_after_joy1", 32'(bus.joy1), 32'hFD);
      end

      // Reset during SETTLE_B with joy1 committed low.
      wait_scans(1);
      tb_p1 = 8'hFE;
      wait_scans(3);
      check("mid_pre_joy1", 32'(bus.joy1), 32'hFE);
      repeat (6) tick();
      check("mid_in_settle_b", 32'(bus.dbg_state), 32'(SETTLE_B));
      rst_n = 1'b0;
      #1;
      check("mid_rst_joy1", 32'(bus.joy1), 32'hFF);
      check("mid_rst_joy2", 32'(bus.joy2), 32'hFF);
      check("mid_rst_coin", 32'(bus.coin), 32'h3);
      check("mid_rst_jselect", 32'(bus.JSELECT), 32'd0);
      check("mid_rst_state", 32'(bus.dbg_state), 32'(SETTLE_A));
      repeat (2) tick();
      rst_n = 1'b1;
      for (int n = 0; n <= 10; n++) begin
         check("restart_jselect", 32'(bus.JSELECT), 32'((n % PERIOD) >= 5));
         check("restart_scan_done", 32'(bus.scan_done), 32'(n == 10));
         if (n < 10) tick();
      end
      check("restart_joy1_partial", 32'(bus.joy1), 32'hFF);
      wait_scans(2);
      check("restart_joy1_final", 32'(bus.joy1), 32'hFE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
